uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one of four byte streams own the UART TX FIFO
// for a whole packet, revoking the grant when the owner goes quiet too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2700
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_fifo_data_in,
    output logic                   tx_fifo_write_en,
    input  logic                   tx_fifo_full,
    output logic                   grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                   timeout_pulse,
    output logic [15:0]            packet_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_last_owner;
    logic             r_timeout_pulse;
    logic [15:0]      r_packet_count;
    logic [15:0]      r_idle_cnt;

    state_t           w_state_nx;
    logic [IDW-1:0]   w_gid_nx;
    logic [IDW-1:0]   w_last_nx;
    logic             w_pulse_nx;
    logic [15:0]      w_pc_nx;
    logic [15:0]      w_cnt_nx;
    logic [15:0]      w_cnt_inc;

    logic             w_in_grant;
    logic             w_own_valid;
    logic             w_own_last;
    logic             w_xfer;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_idx;

    assign w_in_grant  = reset && (r_state == S_GRANT);
    assign w_own_valid = req_valid[r_grant_id];
    assign w_own_last  = req_last[r_grant_id];
    assign w_xfer      = w_in_grant && !tx_fifo_full && w_own_valid;
    assign w_cnt_inc   = r_idle_cnt + 16'd1;

    assign tx_fifo_write_en = w_xfer;
    assign tx_fifo_data_in  = req_data[{r_grant_id, 3'b000} +: 8];
    assign grant_valid      = (r_state == S_GRANT);
    assign grant_id         = r_grant_id;
    assign timeout_pulse    = r_timeout_pulse;
    assign packet_count     = r_packet_count;

    always_comb begin
        req_ready = '0;
        if (w_in_grant && !tx_fifo_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    // Search starts just past the previous owner so it goes to the back.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_owner;
        w_idx    = r_last_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = r_last_owner + IDW'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gid_nx   = r_grant_id;
        w_last_nx  = r_last_owner;
        w_pulse_nx = 1'b0;
        w_pc_nx    = r_packet_count;
        w_cnt_nx   = r_idle_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_GRANT;
                    w_gid_nx   = w_winner;
                    w_cnt_nx   = '0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    w_cnt_nx = '0;
                    if (w_own_last) begin
                        w_state_nx = S_IDLE;
                        w_last_nx  = r_grant_id;
                        w_pc_nx    = r_packet_count + 16'd1;
                    end
                end else if (tx_fifo_full) begin
                    // A full FIFO is backpressure, not an idle requester.
                    w_cnt_nx = '0;
                end else if (!w_own_valid) begin
                    if (w_cnt_inc == LP_TO_LAST) begin
                        w_state_nx = S_IDLE;
                        w_pulse_nx = 1'b1;
                        w_last_nx  = r_grant_id;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_grant_id      <= '0;
            r_last_owner    <= IDW'(NUM_REQ - 1);
            r_timeout_pulse <= 1'b0;
            r_packet_count  <= '0;
            r_idle_cnt      <= '0;
        end else begin
            r_state         <= w_state_nx;
            r_grant_id      <= w_gid_nx;
            r_last_owner    <= w_last_nx;
            r_timeout_pulse <= w_pulse_nx;
            r_packet_count  <= w_pc_nx;
            r_idle_cnt      <= w_cnt_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a packet-level model.
module tb_uart_tx_arbiter;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_fifo_data_in;
    logic        tx_fifo_write_en;
    logic        tx_fifo_full;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        timeout_pulse;
    logic [15:0] packet_count;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .tx_fifo_write_en (tx_fifo_write_en),
        .tx_fifo_full     (tx_fifo_full),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .timeout_pulse    (timeout_pulse),
        .packet_count     (packet_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // requester sources: rem = bytes left in current packet, npk = queued packets
    int         rem[4]  = '{default: 0};
    int         npk[4]  = '{default: 0};
    int         plen[4] = '{default: 0};
    bit         hold[4] = '{default: 1'b0};
    logic [7:0] dat[4]  = '{8'h00, 8'h40, 8'h80, 8'hC0};
    logic [3:0] acc     = 4'b0;

    for (genvar g = 0; g < 4; g++) begin : g_src
        assign req_valid[g]       = (rem[g] > 0) && !hold[g];
        assign req_last[g]        = (rem[g] == 1);
        assign req_data[8*g +: 8] = dat[g];
    end

    // observation logs
    int         glog[$];
    int         wcnt[$];
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         tp_n   = 0;
    int         tp_cyc = 0;
    logic       tp_gv  = 1'b0;
    logic [15:0] tp_pc = 16'd0;
    logic       prev_gv = 1'b0;

    // model: owner = -1 means nobody holds the TX path
    int m_owner = -1;
    int m_gid   = 0;
    int m_last  = 3;
    int m_pkts  = 0;
    int m_quiet = 0;
    bit m_pulse = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            m_owner = -1;
            m_gid   = 0;
            m_last  = 3;
            m_pkts  = 0;
            m_quiet = 0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_owner < 0 && req_valid[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        m_gid   = m_owner;
                        m_quiet = 0;
                    end
                end
            end else if (tx_fifo_full) begin
                m_quiet = 0;
            end else if (req_valid[m_owner]) begin
                m_quiet = 0;
                if (req_last[m_owner]) begin
                    m_pkts  = (m_pkts + 1) % 65536;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TO - 1) begin
                    m_pulse = 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                dat[i] = dat[i] + 8'd1;
                rem[i] = rem[i] - 1;
                if (rem[i] == 0 && npk[i] > 0) begin
                    npk[i] = npk[i] - 1;
                    rem[i] = plen[i];
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [3:0] exp_ready;
        logic       exp_we;
        if (cyc > 0) begin
            exp_ready = 4'b0;
            exp_we    = 1'b0;
            if (reset && m_owner >= 0 && !tx_fifo_full) begin
                exp_ready[m_owner] = 1'b1;
                exp_we = req_valid[m_owner];
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("write_en", 32'(tx_fifo_write_en), 32'(exp_we));
            if (exp_we) begin
                chk("fifo_data", 32'(tx_fifo_data_in),
                    32'(req_data[8*m_owner +: 8]));
            end
            chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
            chk("packet_count", 32'(packet_count), 32'(m_pkts));

            acc = req_ready & req_valid;
            if (grant_valid && !prev_gv) begin
                glog.push_back(int'(grant_id));
                wcnt.push_back(0);
            end
            prev_gv = grant_valid;
            if (tx_fifo_write_en) begin
                wlog.push_back(tx_fifo_data_in);
                wcyc.push_back(cyc);
                if (wcnt.size() > 0) wcnt[wcnt.size()-1]++;
            end
            if (timeout_pulse) begin
                tp_n++;
                tp_cyc = cyc;
                tp_gv  = grant_valid;
                tp_pc  = packet_count;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        tx_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            npk[i]  = 0;
            plen[i] = 0;
            hold[i] = 1'b0;
            dat[i]  = 8'(i * 64);
        end
        repeat (3) tick();
        glog.delete();
        wcnt.delete();
        wlog.delete();
        wcyc.delete();
        tp_n  = 0;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp1[5];
        int exp4[4];
        int w0;
        int bad;
        int s;
        exp1 = '{0, 1, 2, 3, 0};
        exp4 = '{0, 3, 0, 3};
        reset = 1'b0;
        tx_fifo_full = 1'b0;

        // requests while reset is held must see nothing
        for (int i = 0; i < 4; i++) rem[i] = 1;
        repeat (2) tick();
        @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we", 32'(tx_fifo_write_en), 32'h0);
        chk("rst_gv", 32'(grant_valid), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_pc", 32'(packet_count), 32'h0);

        // all four requesters, two-byte packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            plen[i] = 2;
            rem[i]  = 2;
        end
        npk[0] = 1;
        for (int t = 0; t < 100 && packet_count != 16'd5; t++) tick();
        chk("s1_pkts", 32'(packet_count), 32'd5);
        chk("s1_ngrants", 32'(glog.size()), 32'd5);
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            chk("s1_order", 32'(glog[k]), 32'(exp1[k]));
            chk("s1_bytes", 32'(wcnt[k]), 32'd2);
        end

        // owner 2 stalled by a full FIFO for 10 cycles
        do_reset();
        plen[2] = 3;
        rem[2]  = 3;
        for (int t = 0; t < 20 && wlog.size() < 1; t++) tick();
        tx_fifo_full = 1'b1;
        w0  = wlog.size();
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (req_ready[2] || tx_fifo_write_en) bad++;
            tick();
        end
        tx_fifo_full = 1'b0;
        chk("s2_stall_wr", 32'(wlog.size()), 32'(w0));
        chk("s2_stall_rdy", 32'(bad), 32'd0);
        for (int t = 0; t < 20 && packet_count != 16'd1; t++) tick();
        chk("s2_nbytes", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("s2_b0", 32'(wlog[0]), 32'h80);
            chk("s2_b1", 32'(wlog[1]), 32'h81);
            chk("s2_b2", 32'(wlog[2]), 32'h82);
        end
        chk("s2_no_tmo", 32'(tp_n), 32'd0);

        // owner 1 goes quiet after one byte
        do_reset();
        plen[1] = 3;
        rem[1]  = 3;
        plen[2] = 1;
        rem[2]  = 1;
        for (int t = 0; t < 20 && wlog.size() < 1; t++) tick();
        hold[1] = 1'b1;
        for (int t = 0; t < 30 && tp_n < 1; t++) tick();
        repeat (4) tick();
        chk("s3_tmo_count", 32'(tp_n), 32'd1);
        if (wcyc.size() > 0) begin
            chk("s3_tmo_delay", 32'(tp_cyc - wcyc[0]), 32'd8);
        end
        chk("s3_gv_at_tmo", 32'(tp_gv), 32'd0);
        chk("s3_pc_at_tmo", 32'(tp_pc), 32'd0);
        chk("s3_ngrants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) chk("s3_next", 32'(glog[1]), 32'd2);

        // single-byte packets from 0 against a pending 3
        do_reset();
        plen[0] = 1;
        rem[0]  = 1;
        npk[0]  = 6;
        plen[3] = 1;
        rem[3]  = 1;
        npk[3]  = 6;
        for (int t = 0; t < 40 && glog.size() < 4; t++) tick();
        chk("s4_ngrants", 32'(glog.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            chk("s4_order", 32'(glog[k]), 32'(exp4[k]));
        end

        // reset hits the cycle of a last-byte transfer
        do_reset();
        plen[1] = 1;
        rem[1]  = 1;
        for (int t = 0; t < 10 && !grant_valid; t++) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("s5_we", 32'(tx_fifo_write_en), 32'h0);
        tick();
        chk("s5_nwrites", 32'(wlog.size()), 32'd0);
        chk("s5_gv", 32'(grant_valid), 32'h0);
        chk("s5_pc", 32'(packet_count), 32'h0);

        // lone requester 1 with 0xA5
        do_reset();
        dat[1]  = 8'hA5;
        plen[1] = 1;
        rem[1]  = 1;
        s = cyc;
        repeat (6) tick();
        chk("s6_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("s6_data", 32'(wlog[0]), 32'hA5);
            chk("s6_latency", 32'(wcyc[0] - s), 32'd1);
        end

        // randomised traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom % 400 != 0);
            tx_fifo_full = ($urandom % 6 == 0);
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0 && npk[i] == 0 && $urandom % 6 == 0) begin
                    plen[i] = 1 + int'($urandom % 4);
                    rem[i]  = plen[i];
                end
                if ($urandom % 14 == 0) hold[i] = !hold[i];
            end
        end
        reset = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
